// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register with valid/ready handshake.
//
// Carries an opaque DATA_W-bit payload between two pipeline stages. Supports a
// per-stage stall, a synchronous flush (squash), and an optional 2-entry skid
// buffer that removes the combinational out_ready -> in_ready path.
//
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined   : 2-entry skid buffer, count 0..2, in_ready from registered state
//   undefined : single main register, count 0..1, in_ready depends on out_ready
//
// Parameters:
//   DATA_W    payload width
//   RESET_VAL value out_data takes during reset
// Ports:
//   clk        clock, all state changes on its rising edge
//   rst        asynchronous active-low reset
//   stall      freezes the stage (masks in_ready/out_valid, holds state)
//   flush      clears all held entries at the next edge, highest priority
//   in_valid   upstream offers in_data
//   in_ready   stage accepts in_data this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid payload
//   out_ready  downstream consumes this cycle
//   out_data   head payload (holds last registered value when not valid)
//   count      occupancy

module pipe_stage_reg #(
    parameter int unsigned       DATA_W    = 78,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic              accept;
    logic              emit;

    // Stall masks the outgoing valid without touching the stored valid bit.
    assign out_valid = main_valid_q && !stall;
    assign out_data  = main_q;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN

    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    // Ready depends only on registered occupancy, stall and reset.
    assign in_ready = rst && !stall && !skid_valid_q;

    // skid valid implies main valid, so {skid, main & ~skid} is the binary count.
    assign count = {skid_valid_q, main_valid_q && !skid_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!stall) begin
            case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    if (accept) begin
                        main_d       = in_data;
                        main_valid_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (accept && emit) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d       = in_data;
                        skid_valid_d = 1'b1;
                    end else if (emit) begin
                        main_valid_d = 1'b0;
                    end
                end
                2'b11: begin
                    // Full: in_ready is low, only a drain can happen.
                    if (emit) begin
                        main_d       = skid_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    // skid valid without main valid cannot be reached
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q       <= RESET_VAL;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

`else

    // Combinational out_ready -> in_ready: a full stage refills on the drain edge.
    assign in_ready = rst && !stall && (!main_valid_q || out_ready);
    assign count    = {1'b0, main_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (accept) begin
            main_d       = in_data;
            main_valid_d = 1'b1;
        end else if (emit) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q       <= RESET_VAL;
            main_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
        end
    end

`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the generalised successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque DATA_W-bit payload between two pipeline stages. It adds a valid/ready handshake, a synchronous flush for branch/jump squash, a per-stage stall input, and an optional 2-entry skid buffer that cuts the combinational ready path. It sits between any two stages of the core; the stage packs its fields (op, status, mem address, target data, reg address) into `in_data`.

## Interface
- `DATA_W`, default 78: payload width (6 op + 3 status + 32 address + 32 data + 5 reg address).
- `RESET_VAL`, default 0: value `out_data` takes on reset.
- `clk`  in  1: the only clock. All state changes on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `stall`  in  1: this stage's bit of the stall bus. 1 freezes the stage.
- `flush`  in  1: synchronous squash of all held entries.
- `in_valid`  in  1: upstream has a payload.
- `in_ready`  out  1: stage accepts the payload this cycle.
- `in_data`  in  DATA_W: upstream payload.
- `out_valid`  out  1: `out_data` holds a valid payload.
- `out_ready`  in  1: downstream consumes this cycle.
- `out_data`  out  DATA_W: head payload.
- `count`  out  2: occupancy, 0..2 (0..1 without skid).

## Operation
- Accept: `in_valid && in_ready` at a rising edge. Emit: `out_valid && out_ready` at a rising edge.
- Storage:
  - `main` register plus valid bit; `out_data` = `main`.
  - With skid enabled, an additional `skid` register plus valid bit.
- Stall = 1:
  - `in_ready` = 0 and `out_valid` = 0 (masked combinationally).
  - All registers hold; `count` holds.
- Flush = 1:
  - At the next edge, all valid bits clear and `count` becomes 0.
  - Flush takes priority over stall, accept and emit in the same cycle; any offered input is dropped.
  - Data registers keep their contents.
- Without skid:
  - `in_ready` = `!stall && (!main_valid || out_ready)`.
  - On accept, `main` <= `in_data` and valid is set.
  - Emit without accept clears valid.
- With skid, transitions by occupancy:
  - count 0, accept: `main` <= in; count 1.
  - count 1, accept + emit: `main` <= in; count 1.
  - count 1, accept, no emit: `skid` <= in; count 2.
  - count 1, emit only: count 0.
  - count 2, emit: `main` <= `skid`, skid valid clears; count 1.
  - count 2: `in_ready` = 0.
- `out_data` when `out_valid` = 0: holds its last registered value (not forced to zero).

## Timing
- Reset asserted (`rst` = 0), asynchronously:
  - `out_valid` = 0, `count` = 0, `out_data` = `RESET_VAL`, skid cleared.
  - `in_ready` = 1 once `rst` = 1 and `stall` = 0.
- Latency: a payload accepted at edge N is presented with `out_valid` = 1 after edge N.
- Throughput: one payload per cycle with `out_ready` held at 1.
- With skid enabled, `in_ready` is a function of registered state and `stall` only. No combinational path from `out_ready`.
- Without skid, `out_ready` -> `in_ready` is combinational.
- Reset mid-transfer: in-flight payloads are lost. No handshake completes in a cycle where `rst` = 0.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - 2-entry skid buffer; `count` range 0..2.
  - `in_ready` is not combinationally dependent on `out_ready`.
- `PIPE_STAGE_SKID_EN` undefined:
  - single `main` register; `count` range 0..1 (bit 1 tied 0).
  - Combinational ready path as given above; no skid logic synthesised.

## Test plan
- Reset, then `in_valid`=1 with data 0x11,0x22,0x33 on consecutive cycles, `out_ready`=1 -> same sequence on `out_data` one cycle later, `count`=1 steady, no bubbles.
- Skid enabled: accept 0xA1, drop `out_ready` for 2 cycles while offering 0xA2 -> `count`=2, `in_ready`=0. Raise `out_ready` -> 0xA1 then 0xA2 emitted in order, no loss or duplication.
- `stall`=1 for 3 cycles with `count`=1 holding 0x5C -> `out_valid`=0, `in_ready`=0. Release -> 0x5C emitted exactly once.
- `count`=2 and `flush`=1 together with `in_valid`=1 (0x77) and `stall`=1 -> next cycle `count`=0, `out_valid`=0, and 0x77 never appears.
- `rst` pulsed low mid-cycle while holding 0x9E -> `out_valid`=0 and `out_data`=`RESET_VAL` immediately, without waiting for a `clk` edge.
- Skid disabled build: `count`=1, `out_ready`=0 -> `in_ready`=0. `out_ready`=1 in the same cycle -> `in_ready`=1 and new data replaces the old on that edge.
